user_uart_tx_slave: RTL and testbench

USER_UART_TX_SLAVE -- requirements
Module: user_uart_tx_slave

---
 rtl/user_uart_tx_slave_pkg.sv | 11 +
 rtl/user_uart_tx_slave_if.sv | 16 +
 rtl/user_uart_tx_slave_fifo.sv | 35 +++
 rtl/user_uart_tx_slave.sv | 115 +++++++++++
 tb/tb_user_uart_tx_slave.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/user_uart_tx_slave_pkg.sv
// uart_tx_pkg: register offsets, STATUS bit positions and TX FSM states
package uart_tx_pkg;
    localparam logic [1:0] A_TXDATA  = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_BAUDDIV = 2'd2;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_CNT   = 4;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;
endpackage

// File: rtl/user_uart_tx_slave_if.sv
// naive_bus: zero-wait request/grant bus between the core and its peripherals
interface naive_bus;
    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    modport master(output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                   input rd_gnt, rd_data, wr_gnt);
    modport slave(input rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                  output rd_gnt, rd_data, wr_gnt);
endinterface

// File: rtl/user_uart_tx_slave_fifo.sv
// uart_tx_fifo: synchronous FIFO, extra pointer MSB separates full from empty
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign count = wp - rp;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = wp == rp;
    assign dout  = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (push && !full && !rst) mem[wp[AW-1:0]] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/user_uart_tx_slave.sv
// user_uart_tx_slave: naive_bus UART transmitter with byte FIFO and runtime baud divisor
module user_uart_tx_slave
    import uart_tx_pkg::*;
#(
    parameter int DEFAULT_DIV = 434,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic     clk,
    input  logic     rst,
    naive_bus.slave  bus,
    output logic     o_uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [1:0]  wr_sel, rd_sel;
    logic        full, empty, push, pop, txdata_wr, baud_wr;
    logic [AW:0] count;
    logic [3:0]  cnt_sat;
    logic [7:0]  fifo_dout;
    logic [15:0] baud, baud_merged, baud_n, period;
    logic [31:0] status, rd_mux;
    tx_state_t   state, state_n;
    logic [2:0]  bit_idx, bit_n;
    logic [15:0] div_cnt, div_n;
    logic [7:0]  shreg, shreg_n;
    logic        tx_n, last;
    logic        unused_bits;
    assign unused_bits = ^{bus.wr_addr[31:4], bus.wr_addr[1:0], bus.rd_addr[31:4],
                           bus.rd_addr[1:0], bus.wr_data[31:16], bus.wr_be[3:2]};
    assign wr_sel    = bus.wr_addr[3:2];
    assign rd_sel    = bus.rd_addr[3:2];
    assign txdata_wr = bus.wr_req && wr_sel == A_TXDATA && bus.wr_be[0];
    assign bus.rd_gnt = bus.rd_req;
    assign bus.wr_gnt = bus.wr_req && !(txdata_wr && full);
    assign push      = txdata_wr && !full && !rst;
    assign baud_wr   = bus.wr_req && wr_sel == A_BAUDDIV && !rst;
    assign baud_merged = {bus.wr_be[1] ? bus.wr_data[15:8] : baud[15:8],
                          bus.wr_be[0] ? bus.wr_data[7:0]  : baud[7:0]};
    assign baud_n    = baud_merged < 16'd2 ? 16'd2 : baud_merged;
    assign cnt_sat   = (32'(count) > 32'd15) ? 4'hF : 4'(count);
    always_comb begin
        status = '0;
        status[ST_FULL]     = full;
        status[ST_EMPTY]    = empty;
        status[ST_BUSY]     = state != S_IDLE;
        status[ST_CNT +: 4] = cnt_sat;
    end
    assign rd_mux = rd_sel == A_STATUS  ? status :
                    rd_sel == A_BAUDDIV ? {16'h0, baud} : 32'h0;
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data <= '0;
            baud        <= 16'(DEFAULT_DIV);
        end else begin
            if (bus.rd_req) bus.rd_data <= rd_mux;
            if (baud_wr) baud <= baud_n;
        end
    end
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .din(bus.wr_data[7:0]), .pop(pop),
        .dout(fifo_dout), .full(full), .empty(empty), .count(count)
    );
    assign last = div_cnt == period - 16'd1;
    // the line value is derived from the next state so the register stays aligned with it
    always_comb begin
        state_n = state;
        bit_n   = bit_idx;
        div_n   = div_cnt;
        shreg_n = shreg;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: if (!empty) begin
                pop     = 1'b1;
                shreg_n = fifo_dout;
                div_n   = '0;
                bit_n   = '0;
                state_n = S_START;
            end
            S_START: begin
                div_n = last ? 16'd0 : div_cnt + 16'd1;
                if (last) state_n = S_DATA;
            end
            S_DATA: begin
                div_n = last ? 16'd0 : div_cnt + 16'd1;
                if (last) begin
                    shreg_n = shreg >> 1;
                    bit_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = S_STOP;
                end
            end
            S_STOP: begin
                div_n = last ? 16'd0 : div_cnt + 16'd1;
                if (last) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        tx_n = state_n == S_START ? 1'b0 : state_n == S_DATA ? shreg_n[0] : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            o_uart_tx <= 1'b1;
            bit_idx   <= '0;
            div_cnt   <= '0;
            shreg     <= '0;
            period    <= 16'(DEFAULT_DIV);
        end else begin
            state     <= state_n;
            o_uart_tx <= tx_n;
            bit_idx   <= bit_n;
            div_cnt   <= div_n;
            shreg     <= shreg_n;
            if (pop) period <= baud;
        end
    end
endmodule

// File: tb/tb_user_uart_tx_slave.sv
// tb_user_uart_tx_slave: register table, frame-timing sequences and random traffic vs. a UART reference
module tb_user_uart_tx_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    always #5 clk = ~clk;
    naive_bus bus();
    user_uart_tx_slave #(.DEFAULT_DIV(434), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .o_uart_tx(tx)
    );
    localparam logic [31:0] A_TX = 32'h0, A_ST = 32'h4, A_BD = 32'h8, A_RS = 32'hC;
    int n_vec = 0;
    int n_bad = 0;
    int cur_p = 4;
    bit mon_busy = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;
    vec_t tab[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=0x%08h exp=0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, output int waits);
        @(negedge clk);
        bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
        #1;
        waits = 0;
        while (!bus.wr_gnt && waits < 5000) begin
            @(negedge clk); #1; waits++;
        end
        if (!bus.wr_gnt) chk("wr_grant_timeout", 32'(bus.wr_gnt), 32'd1);
        @(posedge clk); #1;
        bus.wr_req = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.rd_req = 1'b1; bus.rd_addr = a;
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        d = bus.rd_data;
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int n = 0;
        do begin
            bus_rd(A_ST, s); n++;
        end while ((s !== 32'h2 || mon_busy) && n < 10000);
        if (n >= 10000) chk("idle_timeout", s, 32'h2);
    endtask

    task automatic compare_rx(input string name);
        chk({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    // reference receiver: samples each bit at its centre using the period the test programmed
    initial begin
        int p;
        logic [7:0] b;
        forever begin
            @(posedge clk); #1;
            if (tx === 1'b0 && !rst) begin
                mon_busy = 1'b1;
                p = cur_p;
                for (int i = 0; i < 8; i++) begin
                    repeat (i == 0 ? p + p / 2 : p) @(posedge clk);
                    #1 b[i] = tx;
                end
                repeat (p) @(posedge clk);
                #1 chk("stop_bit", 32'(tx), 32'd1);
                rx_q.push_back(b);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, d;
        logic [15:0] bd_m, nb;
        logic [3:0] be;
        logic [7:0] pat;
        int w, n, lows;
        bus.rd_req = 0; bus.rd_addr = 0; bus.wr_req = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_be = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("reset_tx", 32'(tx), 32'd1);

        tab[0]  = '{0, A_BD, 32'h0, 4'h0, 32'd434};
        tab[1]  = '{0, A_ST, 32'h0, 4'h0, 32'h2};
        tab[2]  = '{0, A_TX, 32'h0, 4'h0, 32'h0};
        tab[3]  = '{0, A_RS, 32'h0, 4'h0, 32'h0};
        tab[4]  = '{1, A_BD, 32'h1234, 4'b0010, 32'h0};
        tab[5]  = '{0, A_BD, 32'h0, 4'h0, 32'h12B2};
        tab[6]  = '{1, A_BD, 32'h0, 4'b0011, 32'h0};
        tab[7]  = '{0, A_BD, 32'h0, 4'h0, 32'h2};
        tab[8]  = '{1, A_BD, 32'hABCD5678, 4'hF, 32'h0};
        tab[9]  = '{0, A_BD, 32'h0, 4'h0, 32'h5678};
        tab[10] = '{1, A_BD, 32'hFFFFFFFF, 4'b1100, 32'h0};
        tab[11] = '{0, A_BD, 32'h0, 4'h0, 32'h5678};
        tab[12] = '{1, A_RS, 32'h77, 4'hF, 32'h0};
        tab[13] = '{0, A_RS, 32'h0, 4'h0, 32'h0};
        tab[14] = '{1, A_TX, 32'h41, 4'b1110, 32'h0};
        tab[15] = '{0, A_ST, 32'h0, 4'h0, 32'h2};
        for (int i = 0; i < 16; i++) begin
            if (tab[i].is_wr) begin
                bus_wr(tab[i].addr, tab[i].data, tab[i].be, w);
                chk($sformatf("tab%0d_wr_wait", i), 32'(w), 32'd0);
            end else begin
                bus_rd(tab[i].addr, r);
                chk($sformatf("tab%0d_rd", i), r, tab[i].exp);
            end
        end

        // simultaneous read and write of BAUDDIV: read sees the old value
        @(negedge clk);
        bus.rd_req = 1; bus.rd_addr = A_BD;
        bus.wr_req = 1; bus.wr_addr = A_BD; bus.wr_data = 32'h9; bus.wr_be = 4'b0001;
        #1 chk("rd_gnt_comb", 32'(bus.rd_gnt), 32'd1);
        @(posedge clk); #1;
        bus.rd_req = 0; bus.wr_req = 0;
        chk("rdwr_same_cycle_old", bus.rd_data, 32'h5678);
        bus_rd(A_BD, r);
        chk("rdwr_same_cycle_new", r, 32'h5609);

        bd_m = 16'h5609;
        for (int i = 0; i < 16; i++) begin
            d  = (i % 4 == 0) ? 32'($urandom_range(0, 1)) : $urandom;
            be = 4'($urandom_range(0, 15));
            bus_wr(A_BD, d, be, w);
            nb = {be[1] ? d[15:8] : bd_m[15:8], be[0] ? d[7:0] : bd_m[7:0]};
            bd_m = nb < 16'd2 ? 16'd2 : nb;
            bus_rd(A_BD, r);
            chk($sformatf("rand_bd%0d", i), r, {16'h0, bd_m});
        end

        // single 0x55 frame at 4 cycles per bit, exact line shape and busy flag
        cur_p = 4;
        bus_wr(A_BD, 32'd4, 4'b0011, w);
        bus_wr(A_TX, 32'h55, 4'b0001, w);
        exp_q.push_back(8'h55);
        pat = 8'h55;
        @(negedge clk);
        bus.rd_req = 1; bus.rd_addr = A_ST;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (tx !== 1'b0 && n < 20);
        for (int j = 0; j < 41; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
                chk($sformatf("frame_busy%0d", j), 32'(bus.rd_data[2]), 32'd1);
            end
            if (j < 40)
                chk($sformatf("frame_line%0d", j), 32'(tx),
                    32'(j < 4 ? 1'b0 : j < 36 ? pat[(j - 4) / 4] : 1'b1));
        end
        bus.rd_req = 0;
        wait_idle();
        compare_rx("frame55");

        // STATUS read alongside a TXDATA write to an empty FIFO
        @(negedge clk);
        bus.rd_req = 1; bus.rd_addr = A_ST;
        bus.wr_req = 1; bus.wr_addr = A_TX; bus.wr_data = 32'h3C; bus.wr_be = 4'b0001;
        #1 chk("push_empty_gnt", 32'(bus.wr_gnt), 32'd1);
        @(posedge clk); #1;
        bus.wr_req = 0;
        chk("status_pre_push", bus.rd_data, 32'h2);
        @(posedge clk); #1;
        bus.rd_req = 0;
        r = bus.rd_data;
        chk("status_post_push", 32'(r[7:4] == 4'd1 || r[2]), 32'd1);
        exp_q.push_back(8'h3C);
        wait_idle();
        compare_rx("push_empty");

        // fill the FIFO past its depth under a slow baud rate
        cur_p = 20;
        bus_wr(A_BD, 32'd20, 4'b0011, w);
        for (int i = 0; i < 9; i++) begin
            bus_wr(A_TX, 32'(i), 4'b0001, w);
            chk($sformatf("fill%0d_wait", i), 32'(w), 32'd0);
            exp_q.push_back(8'(i));
        end
        bus_wr(A_TX, 32'h9, 4'b0001, w);
        chk("fill9_stalled", 32'(w > 0), 32'd1);
        exp_q.push_back(8'h9);
        wait_idle();
        compare_rx("fill");

        for (int k = 0; k < 3; k++) begin
            cur_p = $urandom_range(2, 6);
            bus_wr(A_BD, 32'(cur_p), 4'b0011, w);
            n = $urandom_range(4, 12);
            for (int i = 0; i < n; i++) begin
                d  = 32'($urandom_range(0, 255));
                be = 4'($urandom_range(0, 15));
                bus_wr(A_TX, d, be, w);
                if (be[0]) exp_q.push_back(d[7:0]);
            end
            wait_idle();
            compare_rx($sformatf("rand%0d", k));
        end

        // reset in the middle of data bit 3 of 0xA5 with three bytes queued
        cur_p = 8;
        bus_wr(A_BD, 32'd8, 4'b0011, w);
        bus_wr(A_TX, 32'hA5, 4'b0001, w);
        bus_wr(A_TX, 32'h01, 4'b0001, w);
        bus_wr(A_TX, 32'h02, 4'b0001, w);
        bus_wr(A_TX, 32'h03, 4'b0001, w);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (tx !== 1'b0 && n < 50);
        repeat (36) @(posedge clk);
        #1 chk("abort_bit3", 32'(tx), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.rd_req = 1; bus.rd_addr = A_BD;
        #1 chk("rd_gnt_in_reset", 32'(bus.rd_gnt), 32'd1);
        @(posedge clk); #1;
        bus.rd_req = 0;
        chk("abort_line_high", 32'(tx), 32'd1);
        @(negedge clk) rst = 1'b0;
        bus_rd(A_ST, r);
        chk("abort_status", r, 32'h2);
        bus_rd(A_BD, r);
        chk("abort_bauddiv", r, 32'd434);
        lows = 0;
        repeat (120) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) lows++;
        end
        chk("abort_no_more_frames", 32'(lows), 32'd0);
        rx_q.delete();
        exp_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
